// File: rtl/ram4k_burst_issuer.sv
// ram4k_burst_issuer: pops 4K-safe chunk entries and issues AXI4 INCR bursts
// on AR or AW, splitting entries longer than MAX_BURST_LEN beats.
module ram4k_burst_issuer #(
    parameter int DATA_BYTES    = 8,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ram4k_empty,
    output logic        ram4k_rd,
    input  logic [82:0] ram4k_rddata,
    output logic        arvalid,
    input  logic        arready,
    output logic [63:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [63:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        chunk_done,
    output logic        entry_err,
    output logic        busy
);
    localparam int          OFF  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 0;
    localparam logic [63:0] MASK = 64'(DATA_BYTES - 1);
    localparam logic [12:0] MAXB = 13'(MAX_BURST_LEN);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [63:0] cur_addr_q, cur_addr_d;
    logic [12:0] beats_left_q, beats_left_d;
    logic        chunk_done_q, chunk_done_d;
    logic        entry_err_q, entry_err_d;
    logic        rd_f, wr_f, valid, hs;
    logic [11:0] bcount;
    logic [63:0] addr_in, span;
    logic [12:0] burst;
    logic        unused_bits;

    assign unused_bits = ^ram4k_rddata[82:78];

    always_comb begin
        rd_f         = ram4k_rddata[77];
        wr_f         = ram4k_rddata[76];
        bcount       = ram4k_rddata[75:64];
        addr_in      = ram4k_rddata[63:0];
        span         = (addr_in & MASK) + {52'b0, bcount} + MASK;
        burst        = (beats_left_q > MAXB) ? MAXB : beats_left_q;
        valid        = state_q == ISSUE;
        hs           = valid & (dir_q ? arready : awready);
        state_d      = state_q;
        dir_d        = dir_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        chunk_done_d = 1'b0;
        entry_err_d  = 1'b0;
        case (state_q)
            IDLE: state_d = ram4k_empty ? IDLE : FETCH;
            FETCH: begin
                entry_err_d = rd_f == wr_f;
                state_d     = (rd_f == wr_f || bcount == 12'd0) ? IDLE : ISSUE;
                dir_d       = rd_f;
                cur_addr_d  = addr_in;
                // Offset of the first beat counts towards the span, so round up over it
                beats_left_d = 13'(span >> OFF);
            end
            ISSUE: begin
                if (hs) begin
                    beats_left_d = beats_left_q - burst;
                    cur_addr_d   = (cur_addr_q & ~MASK) + (64'(burst) << OFF);
                    chunk_done_d = beats_left_q == burst;
                    state_d      = (beats_left_q == burst) ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            chunk_done_q <= 1'b0;
            entry_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            chunk_done_q <= chunk_done_d;
            entry_err_q  <= entry_err_d;
        end
    end

    // reset_n gates the pop so nothing is consumed while held in reset
    assign ram4k_rd   = reset_n & (state_q == IDLE) & ~ram4k_empty;
    assign arvalid    = valid & dir_q;
    assign awvalid    = valid & ~dir_q;
    assign araddr     = arvalid ? cur_addr_q : '0;
    assign awaddr     = awvalid ? cur_addr_q : '0;
    assign arlen      = arvalid ? 8'(burst - 13'd1) : '0;
    assign awlen      = awvalid ? 8'(burst - 13'd1) : '0;
    assign arsize     = 3'(OFF);
    assign awsize     = 3'(OFF);
    assign arburst    = 2'b01;
    assign awburst    = 2'b01;
    assign chunk_done = chunk_done_q;
    assign entry_err  = entry_err_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_ram4k_burst_issuer.sv
// tb_ram4k_burst_issuer: directed entries against a burst-list model of the
// issuer, checked every cycle, plus literal expectations per scenario.
module tb_ram4k_burst_issuer;
    localparam int DB  = 8;
    localparam int MAX = 256;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        ram4k_empty;
    logic        ram4k_rd;
    logic [82:0] ram4k_rddata = '0;
    logic        arvalid, arready = 0, awvalid, awready = 0;
    logic [63:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        chunk_done, entry_err, busy;

    ram4k_burst_issuer #(.DATA_BYTES(DB), .MAX_BURST_LEN(MAX)) dut (
        .clk(clk), .reset_n(reset_n), .ram4k_empty(ram4k_empty), .ram4k_rd(ram4k_rd),
        .ram4k_rddata(ram4k_rddata), .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .awvalid(awvalid),
        .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .chunk_done(chunk_done), .entry_err(entry_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dir;
        logic [63:0] addr;
        logic [7:0]  len;
        bit          last;
    } burst_t;

    burst_t      exp_q[$];
    logic [82:0] mem[0:63];
    int          rp = 0, wp = 0;
    int          vectors = 0, miscompares = 0;
    int          done_cnt = 0, err_cnt = 0, cyc = 0;
    logic [63:0] hs_addr[$];
    logic [7:0]  hs_len[$];
    bit          hs_dir[$];
    int          hs_cyc[$];

    assign ram4k_empty = (rp == wp);

    always @(posedge clk) begin
        if (ram4k_rd) begin
            ram4k_rddata <= mem[rp];
            rp <= rp + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Bursts of an entry: first one starts at the raw address, the rest at
    // aligned base + k full bursts.
    task automatic push(input bit rd, input bit wr, input int bc, input logic [63:0] a);
        int off, beats, n, k;
        burst_t b;
        mem[wp] = {5'b0, rd, wr, 12'(bc), a};
        wp++;
        if (rd != wr && bc != 0) begin
            off = int'(a % DB);
            beats = (off + bc + DB - 1) / DB;
            k = 0;
            while (beats > 0) begin
                n = (beats > MAX) ? MAX : beats;
                b.dir  = rd;
                b.addr = (k == 0) ? a : (a - 64'(off)) + 64'(k) * 64'(MAX * DB);
                b.len  = 8'(n - 1);
                b.last = (beats == n);
                exp_q.push_back(b);
                beats -= n;
                k++;
            end
        end
    endtask

    bit prev_v = 0, prev_hs = 0, done_p = 0, err_p1 = 0, err_p2 = 0;

    always @(negedge clk) begin
        bit v, hs;
        logic [82:0] e;
        cyc++;
        if (!reset_n) begin
            prev_v = 0; prev_hs = 0; done_p = 0; err_p1 = 0; err_p2 = 0;
        end else begin
            v  = arvalid | awvalid;
            hs = arvalid ? arready : (awvalid & awready);
            chk("both_valid", 64'(arvalid & awvalid), 0);
            chk("chunk_done", 64'(chunk_done), 64'(done_p));
            chk("entry_err", 64'(entry_err), 64'(err_p2));
            chk("rd_when_empty", 64'(ram4k_rd & ram4k_empty), 0);
            chk("rd_when_busy", 64'(ram4k_rd & busy), 0);
            if (prev_v && !prev_hs) chk("valid_dropped", 64'(v), 1);
            done_cnt += chunk_done;
            err_cnt += entry_err;
            err_p2 = err_p1;
            err_p1 = 0;
            done_p = 0;
            if (ram4k_rd) begin
                e = mem[rp];
                err_p1 = (e[77] == e[76]);
            end
            if (v) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 64'(v), 0);
                else begin
                    chk("dir", 64'(arvalid), 64'(exp_q[0].dir));
                    chk("addr", arvalid ? araddr : awaddr, exp_q[0].addr);
                    chk("len", 64'(arvalid ? arlen : awlen), 64'(exp_q[0].len));
                    chk("size", 64'(arvalid ? arsize : awsize), 3);
                    chk("burst", 64'(arvalid ? arburst : awburst), 1);
                    if (hs) begin
                        done_p = exp_q[0].last;
                        hs_addr.push_back(arvalid ? araddr : awaddr);
                        hs_len.push_back(arvalid ? arlen : awlen);
                        hs_dir.push_back(arvalid);
                        hs_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_v = v;
            prev_hs = hs;
        end
    end

    task automatic clear_log();
        hs_addr.delete(); hs_len.delete(); hs_dir.delete(); hs_cyc.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rp != wp || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, 64'(n < 3000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, e0, n;
        logic [63:0] a0;
        logic [7:0]  l0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_awvalid", 64'(awvalid), 0);
        chk("rst_rd", 64'(ram4k_rd), 0);
        reset_n = 1;
        @(posedge clk); #1;
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_arlen", 64'(arlen), 0);
        chk("rst_awlen", 64'(awlen), 0);
        chk("rst_done", 64'(chunk_done), 0);
        chk("rst_err", 64'(entry_err), 0);
        chk("const_arsize", 64'(arsize), 3);
        chk("const_awburst", 64'(awburst), 1);

        arready = 1; awready = 1;
        clear_log(); d0 = done_cnt;
        push(0, 1, 64, 64'h1000_0010);
        drain("write");
        chk("write_nbursts", 64'(hs_addr.size()), 1);
        if (hs_addr.size() == 1) begin
            chk("write_addr", hs_addr[0], 64'h1000_0010);
            chk("write_len", 64'(hs_len[0]), 7);
            chk("write_is_aw", 64'(hs_dir[0]), 0);
        end
        chk("write_done", 64'(done_cnt - d0), 1);

        clear_log();
        push(1, 0, 10, 64'h2000_0003);
        drain("read");
        chk("read_nbursts", 64'(hs_addr.size()), 1);
        if (hs_addr.size() == 1) begin
            chk("read_addr", hs_addr[0], 64'h2000_0003);
            chk("read_len", 64'(hs_len[0]), 1);
            chk("read_is_ar", 64'(hs_dir[0]), 1);
        end

        clear_log(); d0 = done_cnt;
        push(1, 0, 4095, 64'h3000_0001);
        drain("split");
        chk("split_nbursts", 64'(hs_addr.size()), 2);
        if (hs_addr.size() == 2) begin
            chk("split_addr0", hs_addr[0], 64'h3000_0001);
            chk("split_len0", 64'(hs_len[0]), 255);
            chk("split_addr1", hs_addr[1], 64'h3000_0800);
            chk("split_len1", 64'(hs_len[1]), 255);
            chk("split_b2b", 64'(hs_cyc[1] - hs_cyc[0]), 1);
        end
        chk("split_done", 64'(done_cnt - d0), 1);

        clear_log();
        awready = 0;
        push(0, 1, 16, 64'h4000_0000);
        n = 0;
        while (!awvalid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_valid_seen", 64'(awvalid), 1);
        a0 = awaddr; l0 = awlen;
        chk("bp_addr_lit", a0, 64'h4000_0000);
        chk("bp_len_lit", 64'(l0), 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(awvalid), 1);
            chk("bp_hold_addr", awaddr, a0);
            chk("bp_hold_len", 64'(awlen), 64'(l0));
        end
        awready = 1;
        drain("bp");
        chk("bp_nbursts", 64'(hs_addr.size()), 1);

        clear_log(); d0 = done_cnt; e0 = err_cnt;
        push(1, 1, 8, 64'h5000_0000);
        push(0, 0, 8, 64'h5000_0100);
        push(1, 0, 0, 64'h5000_0200);
        push(1, 0, 32, 64'h5000_0008);
        drain("flags");
        chk("flags_err_pulses", 64'(err_cnt - e0), 2);
        chk("flags_nbursts", 64'(hs_addr.size()), 1);
        if (hs_addr.size() == 1) begin
            chk("flags_addr", hs_addr[0], 64'h5000_0008);
            chk("flags_len", 64'(hs_len[0]), 3);
        end
        chk("flags_done", 64'(done_cnt - d0), 1);

        arready = 0;
        push(1, 0, 64, 64'h6000_0000);
        n = 0;
        while (!arvalid && n < 50) begin @(posedge clk); #1; n++; end
        chk("rst_mid_valid_seen", 64'(arvalid), 1);
        reset_n = 0;
        #1;
        chk("rst_mid_arvalid", 64'(arvalid), 0);
        chk("rst_mid_busy", 64'(busy), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        arready = 1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("post_rst_busy", 64'(busy), 0);
            chk("post_rst_arvalid", 64'(arvalid), 0);
            chk("post_rst_rd", 64'(ram4k_rd), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
